// File: rtl/gen_event_counter_bank.sv
// gen_event_counter_bank
//
// Bank of CHANNELS independent event counters. A snapshot request taken in
// IDLE copies every counter into a shadow register at one clock edge, so the
// captured set is coherent across channels. The shadows are then streamed out
// over a valid/ready interface, one channel per beat, in channel order 0..N-1.
//
// Parameters:
//   CHANNELS      number of counter channels (>=1)
//   WIDTH         counter / output data width
//   MODE          0 = wrap to zero on overflow, 1 = saturate at all-ones
//   CLEAR_ON_SNAP 1 = counters and overflow flags restart on a snapshot
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   i_evt    per-channel event strobe, one count per cycle while high
//   i_snap   snapshot request, only honoured in IDLE
//   i_ready  downstream ready
//   o_valid  beat valid
//   o_chan   channel index of the current beat
//   o_data   captured count of channel o_chan
//   o_busy   high while a snapshot is being streamed out
//   o_ovf    live sticky overflow flag per channel

module gen_event_counter_bank #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 8,
  parameter int MODE          = 0,
  parameter int CLEAR_ON_SNAP = 1,
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] i_evt,
  input  logic                i_snap,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [CW-1:0]       o_chan,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_busy,
  output logic [CHANNELS-1:0] o_ovf
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    next_idx;
  logic             last_beat;
  logic             snap_take;
  logic [WIDTH-1:0] cnt_bus    [CHANNELS];
  logic [WIDTH-1:0] shadow_bus [CHANNELS];

  // A snapshot is only taken from IDLE; requests during a scan are dropped.
  assign snap_take = (state == IDLE) && i_snap;
  assign next_idx  = idx + CW'(1);
  assign last_beat = (idx == CW'(CHANNELS - 1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] cnt_inc;
    logic             ovf;
    logic             at_max;
    logic             clear_now;

    assign at_max = (cnt == {WIDTH{1'b1}});

    // Next count value when an event arrives, chosen by overflow policy.
    case (MODE)
      0: begin : g_wrap
        assign cnt_inc = cnt + WIDTH'(1);
      end
      1: begin : g_sat
        assign cnt_inc = at_max ? cnt : cnt + WIDTH'(1);
      end
      default: begin : g_bad_mode
        $error("gen_event_counter_bank: MODE must be 0 (wrap) or 1 (saturate)");
        assign cnt_inc = cnt;
      end
    endcase

    if (CLEAR_ON_SNAP != 0) begin : g_clear
      assign clear_now = snap_take;
    end else begin : g_keep
      assign clear_now = 1'b0;
    end

    // On a clearing snapshot the counter restarts at the event of the same
    // cycle, so that event lands in the next snapshot instead of being lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (clear_now) begin
        cnt <= WIDTH'(i_evt[c]);
        ovf <= 1'b0;
      end else if (i_evt[c]) begin
        cnt <= cnt_inc;
        if (at_max) begin
          ovf <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
      end else if (snap_take) begin
        shadow <= cnt;
      end
    end

    assign cnt_bus[c]    = cnt;
    assign shadow_bus[c] = shadow;
    assign o_ovf[c]      = ovf;
  end

  // Scan sequencer. The first beat is loaded straight from the live counter
  // because its shadow is being written at the same edge with that value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_chan  <= '0;
      o_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_snap) begin
            state   <= SCAN;
            idx     <= '0;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
            o_chan  <= '0;
            o_data  <= cnt_bus[0];
          end
        end
        SCAN: begin
          if (o_valid && i_ready) begin
            if (last_beat) begin
              state   <= IDLE;
              idx     <= '0;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_chan  <= '0;
              o_data  <= '0;
            end else begin
              idx    <= next_idx;
              o_chan <= next_idx;
              o_data <= shadow_bus[next_idx];
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gen_event_counter_bank.sv
// tb_gen_event_counter_bank
//
// Directed bench for gen_event_counter_bank. Instance u_dut uses the default
// parameters (4 channels, 8 bits, wrap, clear on snapshot); instance u_sat
// uses 4-bit saturating counters that keep running across snapshots.

module tb_gen_event_counter_bank;

  logic       clk;
  logic       rst_n;

  logic [3:0] evt;
  logic       snap;
  logic       ready;
  logic       valid;
  logic [1:0] chan;
  logic [7:0] data;
  logic       busy;
  logic [3:0] ovf;

  logic [3:0] evt_s;
  logic       snap_s;
  logic       ready_s;
  logic       valid_s;
  logic [1:0] chan_s;
  logic [3:0] data_s;
  logic       busy_s;
  logic [3:0] ovf_s;

  int assertCount = 0;
  int failCount   = 0;

  gen_event_counter_bank #(
    .CHANNELS(4), .WIDTH(8), .MODE(0), .CLEAR_ON_SNAP(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_evt(evt), .i_snap(snap), .i_ready(ready),
    .o_valid(valid), .o_chan(chan), .o_data(data), .o_busy(busy), .o_ovf(ovf)
  );

  gen_event_counter_bank #(
    .CHANNELS(4), .WIDTH(4), .MODE(1), .CLEAR_ON_SNAP(0)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .i_evt(evt_s), .i_snap(snap_s), .i_ready(ready_s),
    .o_valid(valid_s), .o_chan(chan_s), .o_data(data_s), .o_busy(busy_s), .o_ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] e, input logic s, input logic r, input int cycles);
    evt   = e;
    snap  = s;
    ready = r;
    repeat (cycles) tick();
  endtask

  task automatic checkBeat(input string tag, input logic v, input int ch, input int d);
    checkOutput({tag, ".valid"}, 32'(valid), 32'(v));
    checkOutput({tag, ".busy"},  32'(busy),  32'(v));
    checkOutput({tag, ".chan"},  32'(chan),  32'(ch));
    checkOutput({tag, ".data"},  32'(data),  32'(d));
  endtask

  task automatic checkBeatSat(input string tag, input logic v, input int ch, input int d);
    checkOutput({tag, ".valid"}, 32'(valid_s), 32'(v));
    checkOutput({tag, ".busy"},  32'(busy_s),  32'(v));
    checkOutput({tag, ".chan"},  32'(chan_s),  32'(ch));
    checkOutput({tag, ".data"},  32'(data_s),  32'(d));
  endtask

  initial begin
    rst_n   = 1'b0;
    evt     = '0;
    snap    = 1'b0;
    ready   = 1'b0;
    evt_s   = '0;
    snap_s  = 1'b0;
    ready_s = 1'b0;

    // Reset state.
    tick();
    tick();
    checkBeat("rst", 1'b0, 0, 0);
    checkOutput("rst.ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;

    // Basic snapshot: ch0 gets 3 events, ch2 gets 7.
    applyStimulus(4'b0101, 1'b0, 1'b1, 3);
    applyStimulus(4'b0100, 1'b0, 1'b1, 4);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1);
    snap = 1'b0;
    checkBeat("basic.b0", 1'b1, 0, 3);
    tick(); checkBeat("basic.b1", 1'b1, 1, 0);
    tick(); checkBeat("basic.b2", 1'b1, 2, 7);
    tick(); checkBeat("basic.b3", 1'b1, 3, 0);
    tick(); checkBeat("basic.idle", 1'b0, 0, 0);

    // Clear-on-snap boundary, backpressure, and snap ignored while busy.
    applyStimulus(4'b1000, 1'b0, 1'b0, 2);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1);
    checkBeat("bp.b0", 1'b1, 0, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1); checkBeat("bp.hold0a", 1'b1, 0, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1); checkBeat("bp.hold0b", 1'b1, 0, 0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1); checkBeat("bp.b1", 1'b1, 1, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1); checkBeat("bp.hold1", 1'b1, 1, 0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1); checkBeat("bp.b2", 1'b1, 2, 0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1); checkBeat("bp.b3", 1'b1, 3, 2);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1); checkBeat("bp.idle", 1'b0, 0, 0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1);
    snap = 1'b0;
    checkBeat("resnap.b0", 1'b1, 0, 0);
    tick(); checkBeat("resnap.b1", 1'b1, 1, 0);
    tick(); checkBeat("resnap.b2", 1'b1, 2, 0);
    tick(); checkBeat("resnap.b3", 1'b1, 3, 1);
    tick(); checkBeat("resnap.idle", 1'b0, 0, 0);
    checkOutput("resnap.ovf", 32'(ovf), 32'h0);

    // Wrap: 258 events on ch1 of an 8-bit counter leave 2 and set the flag.
    applyStimulus(4'b0010, 1'b0, 1'b1, 258);
    checkOutput("wrap.ovf_set", 32'(ovf), 32'h2);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1);
    snap = 1'b0;
    checkBeat("wrap.b0", 1'b1, 0, 0);
    checkOutput("wrap.ovf_cleared", 32'(ovf), 32'h0);
    tick(); checkBeat("wrap.b1", 1'b1, 1, 2);
    tick(); checkBeat("wrap.b2", 1'b1, 2, 0);
    tick(); checkBeat("wrap.b3", 1'b1, 3, 0);
    tick(); checkBeat("wrap.idle", 1'b0, 0, 0);

    // Saturating, non-clearing instance: 18 events on ch1 hold at 15.
    evt_s = 4'b0010; ready_s = 1'b1;
    repeat (18) tick();
    checkOutput("sat.ovf_set", 32'(ovf_s), 32'h2);
    evt_s = 4'b0000; snap_s = 1'b1;
    tick();
    snap_s = 1'b0;
    checkBeatSat("sat.b0", 1'b1, 0, 0);
    tick(); checkBeatSat("sat.b1", 1'b1, 1, 15);
    tick(); checkBeatSat("sat.b2", 1'b1, 2, 0);
    tick(); checkBeatSat("sat.b3", 1'b1, 3, 0);
    tick(); checkBeatSat("sat.idle", 1'b0, 0, 0);
    checkOutput("sat.ovf_kept", 32'(ovf_s), 32'h2);

    // Non-clearing boundary: the snap-cycle event is excluded, then kept.
    evt_s = 4'b1000;
    repeat (2) tick();
    snap_s = 1'b1;
    tick();
    evt_s = 4'b0000; snap_s = 1'b0;
    checkBeatSat("keep.b0", 1'b1, 0, 0);
    tick(); checkBeatSat("keep.b1", 1'b1, 1, 15);
    tick(); checkBeatSat("keep.b2", 1'b1, 2, 0);
    tick(); checkBeatSat("keep.b3", 1'b1, 3, 2);
    tick(); checkBeatSat("keep.idle", 1'b0, 0, 0);
    snap_s = 1'b1;
    tick();
    snap_s = 1'b0;
    tick();
    checkBeatSat("keep2.b1", 1'b1, 1, 15);
    tick();
    tick(); checkBeatSat("keep2.b3", 1'b1, 3, 3);
    tick(); checkBeatSat("keep2.idle", 1'b0, 0, 0);
    checkOutput("keep2.ovf", 32'(ovf_s), 32'h2);

    // Reset asserted mid-scan with beat 2 pending.
    applyStimulus(4'b0001, 1'b0, 1'b1, 5);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1);
    snap = 1'b0;
    checkBeat("mid.b0", 1'b1, 0, 5);
    tick(); checkBeat("mid.b1", 1'b1, 1, 0);
    tick(); checkBeat("mid.b2", 1'b1, 2, 0);
    ready = 1'b0;
    tick(); checkBeat("mid.b2hold", 1'b1, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkBeat("midrst", 1'b0, 0, 0);
    checkOutput("midrst.ovf", 32'(ovf), 32'h0);
    checkOutput("midrst.ovf_s", 32'(ovf_s), 32'h0);
    tick();
    checkBeat("midrst.held", 1'b0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b1, 1);
    snap = 1'b0;
    checkBeat("post.b0", 1'b1, 0, 0);
    tick(); checkBeat("post.b1", 1'b1, 1, 0);
    tick(); checkBeat("post.b2", 1'b1, 2, 0);
    tick(); checkBeat("post.b3", 1'b1, 3, 0);
    tick(); checkBeat("post.idle", 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
